// File: rtl/cla64_operand_sequencer.sv
// -----------------------------------------------------------------------------
// cla64_operand_sequencer
//
// Purpose:
//   This stage sits in front of the 64-bit carry-lookahead adder. It collects
//   operand A, operand B and a carry-in from a little-endian byte stream. It
//   holds them stable on the combinational adder while the adder settles, then
//   registers the returned sum. The sum is offered downstream on a
//   valid/ready handshake.
//
// Optional feature (compile-time macro):
//   CLA64_CARRY_OUT_EN - adds the out_cout port. This is the carry out of
//                        bit 63, captured together with out_sum.
//
// Parameters:
//   SETTLE_CYCLES  cycles the operands are held on the adder before capture
//                  (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_byte / in_cin valid
//   in_ready   a byte is accepted this cycle
//   in_byte    operand byte, first byte = bits 7:0
//   in_cin     carry-in, sampled only with the first byte of A
//   add_a      operand A to adder
//   add_b      operand B to adder
//   add_cin    carry-in to adder
//   add_sum    combinational sum from adder
//   out_valid  out_sum valid
//   out_ready  downstream accepts the result
//   out_sum    registered sum
//   out_cout   registered carry out (only with CLA64_CARRY_OUT_EN)
// -----------------------------------------------------------------------------
module cla64_operand_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_cin,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    output logic        add_cin,
    input  logic [63:0] add_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum
`ifdef CLA64_CARRY_OUT_EN
    ,
    output logic        out_cout
`endif
);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        SETTLE,
        OUT
    } state_t;

    // The capture happens in the cycle the counter reads zero. Loading
    // SETTLE_CYCLES therefore makes out_valid rise SETTLE_CYCLES+1 edges
    // after the final B byte is taken.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [2:0] byte_cnt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       last_byte;
    logic       capture;

    assign accept    = in_valid & in_ready;
    assign last_byte = (byte_cnt == 3'd7);

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode.
    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        case (state)
            LOAD_A: begin
                // The reset state is LOAD_A. Gating with rst_n keeps in_ready
                // low while reset is held.
                in_ready = rst_n;
                if (accept && last_byte) state_nx = LOAD_B;
            end
            LOAD_B: begin
                in_ready = rst_n;
                if (accept && last_byte) state_nx = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = LOAD_A;
            end
            default: state_nx = LOAD_A;
        endcase
    end

    // Operand assembly, settle timer and result capture. Operand bytes are
    // overwritten one at a time. Bytes not yet rewritten keep their old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            out_sum    <= '0;
        end else begin
            if (accept) begin
                // byte_cnt is 3 bits, so it wraps to 0 after the eighth byte.
                byte_cnt <= byte_cnt + 3'd1;
                if (state == LOAD_A) begin
                    add_a[{byte_cnt, 3'b000} +: 8] <= in_byte;
                    if (byte_cnt == 3'd0) add_cin <= in_cin;
                end else begin
                    add_b[{byte_cnt, 3'b000} +: 8] <= in_byte;
                    if (last_byte) settle_cnt <= SETTLE_LOAD;
                end
            end
            if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                out_sum <= add_sum;
            end
        end
    end

`ifdef CLA64_CARRY_OUT_EN
    // The carry into bit 63 is recovered from the sum bit. The carry out then
    // follows from the usual generate/propagate form.
    logic c63;
    assign c63 = add_sum[63] ^ add_a[63] ^ add_b[63];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cout <= 1'b0;
        end else if (capture) begin
            out_cout <= (add_a[63] & add_b[63]) | ((add_a[63] ^ add_b[63]) & c63);
        end
    end
`endif

endmodule

// File: tb/tb_cla64_operand_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cla64_operand_sequencer.
//
// Two instances are used: index 0 with SETTLE_CYCLES=1 and index 1 with
// SETTLE_CYCLES=4. Each instance has its own stimulus signals. The bench acts
// as the adder for each instance. Expected results come from plain 65-bit
// arithmetic on the operands the bench sent.
// -----------------------------------------------------------------------------
module tb_cla64_operand_sequencer;

    localparam int SC0 = 1;
    localparam int SC1 = 4;

    int checks = 0;
    int errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_byte   [2];
    logic        in_cin    [2];
    logic [63:0] add_a     [2];
    logic [63:0] add_b     [2];
    logic        add_cin   [2];
    logic [63:0] add_sum   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_sum   [2];
`ifdef CLA64_CARRY_OUT_EN
    logic        out_cout  [2];
`endif

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational adder.
    assign add_sum[0] = add_a[0] + add_b[0] + {63'd0, add_cin[0]};
    assign add_sum[1] = add_a[1] + add_b[1] + {63'd0, add_cin[1]};

    cla64_operand_sequencer #(.SETTLE_CYCLES(SC0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_byte(in_byte[0]), .in_cin(in_cin[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_sum(add_sum[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0])
`ifdef CLA64_CARRY_OUT_EN
        , .out_cout(out_cout[0])
`endif
    );

    cla64_operand_sequencer #(.SETTLE_CYCLES(SC1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_byte(in_byte[1]), .in_cin(in_cin[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_sum(add_sum[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1])
`ifdef CLA64_CARRY_OUT_EN
        , .out_cout(out_cout[1])
`endif
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? SC0 : SC1;
    endfunction

    // Offer one byte and wait until it is taken. Inputs change 1 ns after
    // the rising edge. in_ready is sampled on the falling edge.
    task automatic send_byte(input int d, input logic [7:0] b, input logic c, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) begin
            in_valid[d] = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid[d] = 1'b1;
        in_byte[d]  = b;
        in_cin[d]   = c;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept dut%0d: in_ready never seen, required 1", d);
        end
    endtask

    // in_cin is randomised on the bytes where the sequencer must ignore it.
    task automatic send_word(input int d, input logic [63:0] w, input logic cin, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            send_byte(d, w[8*k +: 8], (k == 0) ? cin : 1'($urandom), gaps);
        end
    endtask

    // One full transaction. If hold is nonzero, out_ready stays low for
    // hold cycles after out_valid rises. Stray bytes are offered during
    // that stall and must be ignored.
    task automatic do_txn(input int d, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input bit gaps, input int hold, input string name);
        logic [64:0] full;
        logic [63:0] held;
        int          n;
        bit          early_ready;
        full         = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        out_ready[d] = (hold == 0);
        send_word(d, a, cin, gaps);
        send_word(d, b, 1'($urandom), gaps);

        checks++;
        if ({add_a[d], add_b[d], add_cin[d]} !== {a, b, cin}) begin
            errors++;
            $display("FAIL %s operands dut%0d: got a=%h b=%h cin=%b, required a=%h b=%h cin=%b",
                     name, d, add_a[d], add_b[d], add_cin[d], a, b, cin);
        end

        n           = 0;
        early_ready = 1'b0;
        while (n < 40 && out_valid[d] !== 1'b1) begin
            if (in_ready[d] !== 1'b0) early_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != settle_of(d) + 1 || out_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s latency dut%0d: out_valid after %0d edges, required %0d",
                     name, d, n, settle_of(d) + 1);
        end
        checks++;
        if (early_ready) begin
            errors++;
            $display("FAIL %s settle_in_ready dut%0d: got 1 during settle, required 0", name, d);
        end
        checks++;
        if (out_sum[d] !== full[63:0]) begin
            errors++;
            $display("FAIL %s sum dut%0d: got %h, required %h", name, d, out_sum[d], full[63:0]);
        end
`ifdef CLA64_CARRY_OUT_EN
        checks++;
        if (out_cout[d] !== full[64]) begin
            errors++;
            $display("FAIL %s cout dut%0d: got %b, required %b", name, d, out_cout[d], full[64]);
        end
`endif

        held = out_sum[d];
        for (int h = 0; h < hold; h++) begin
            in_valid[d] = 1'b1;
            in_byte[d]  = 8'($urandom);
            in_cin[d]   = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid[d], in_ready[d], out_sum[d]} !== {1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL %s stall dut%0d cycle %0d: got valid=%b ready=%b sum=%h, required 1 0 %h",
                         name, d, h, out_valid[d], in_ready[d], out_sum[d], held);
            end
        end
        if (hold > 0) begin
            in_valid[d] = 1'b0;
            checks++;
            if ({add_a[d], add_b[d], add_cin[d]} !== {a, b, cin}) begin
                errors++;
                $display("FAIL %s ignored_bytes dut%0d: got a=%h b=%h cin=%b, required a=%h b=%h cin=%b",
                         name, d, add_a[d], add_b[d], add_cin[d], a, b, cin);
            end
        end

        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid[d], in_ready[d]} !== 2'b01) begin
            errors++;
            $display("FAIL %s release dut%0d: got valid=%b ready=%b, required 0 1",
                     name, d, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic expect_reset_state(input int d, input string name);
        checks++;
        if ({in_ready[d], out_valid[d], add_cin[d], add_a[d], add_b[d], out_sum[d]} !== '0) begin
            errors++;
            $display("FAIL %s dut%0d: got ready=%b valid=%b cin=%b a=%h b=%h sum=%h, required all 0",
                     name, d, in_ready[d], out_valid[d], add_cin[d], add_a[d], add_b[d], out_sum[d]);
        end
`ifdef CLA64_CARRY_OUT_EN
        checks++;
        if (out_cout[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s cout dut%0d: got %b, required 0", name, d, out_cout[d]);
        end
`endif
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_byte[d]   = '0;
            in_cin[d]    = 1'b0;
            out_ready[d] = 1'b1;
        end
        rst_n = 1'b0;
        #2;
        expect_reset_state(0, "reset0");
        expect_reset_state(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready[0], in_ready[1]} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b%b, required 11", in_ready[0], in_ready[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_txn(0, 64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0, 1'b0, 0, "basic");
        do_txn(0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 0, "overflow");
    endtask

    task automatic test_stall();
        do_txn(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, 5, "stall");
    endtask

    task automatic test_gaps();
        do_txn(1, 64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b1, 0, "gaps_msb");
        do_txn(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, 0, "gaps_rand");
    endtask

    task automatic test_reset_mid();
        int n;
        // Reset after three A bytes.
        for (int k = 0; k < 3; k++) send_byte(0, 8'($urandom), 1'($urandom), 1'b0);
        rst_n = 1'b0;
        #1;
        expect_reset_state(0, "reset_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, 0, "after_load_reset");

        // Reset during SETTLE on the four-cycle instance.
        send_word(1, {$urandom, $urandom}, 1'($urandom), 1'b0);
        send_word(1, {$urandom, $urandom}, 1'($urandom), 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        expect_reset_state(1, "reset_mid_settle");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, 0, "after_settle_reset");

        // Reset while the result is waiting in OUT.
        out_ready[0] = 1'b0;
        send_word(0, {$urandom, $urandom}, 1'($urandom), 1'b0);
        send_word(0, {$urandom, $urandom}, 1'($urandom), 1'b0);
        n = 0;
        while (n < 40 && out_valid[0] !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_out_reach: got out_valid=%b, required 1", out_valid[0]);
        end
        rst_n = 1'b0;
        #1;
        expect_reset_state(0, "reset_in_out");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_txn(0, 64'd5, 64'd7, 1'b0, 1'b0, 0, "b2b_first");
        do_txn(0, 64'd5, 64'd7, 1'b1, 1'b0, 0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_txn(int'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
